// File: rtl/v200_clkrst_seq.sv
// Clock-enable and reset sequencer for the V200 core: synchronised POR release,
// reset stretch, CLKEN rate divider and a 4-phase software reset handshake.
module v200_clkrst_seq #(
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DIV_W          = 4
) (
    input  logic             CLK2X,
    input  logic             NATIVEPORRESET_n,
    input  logic             SWRESET_REQ,
    output logic             SWRESET_ACK,
    input  logic [DIV_W-1:0] DIV_RATIO,
    input  logic             HALT,
    output logic             CLKEN,
    output logic             CORE_RESET_n,
    output logic             RUN,
    output logic [31:0]      CLKEN_COUNT
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_STRETCH,
        ST_RUN,
        ST_SWRST,
        ST_ACKW
    } state_t;

    localparam logic [15:0]      STRETCH_LOAD = 16'(STRETCH_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);

    state_t           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             rst_ok;
    logic [15:0]      stretch_cnt;
    logic             stretch_load;
    logic             count_clr;
    logic [DIV_W-1:0] div_cnt;
    logic [31:0]      count_q;
    logic             run_q, run_d;
    logic             core_rst_n_q;

    // Reset-release synchroniser: assertion is async, release shifts in a 1.
    always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
        if (!NATIVEPORRESET_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_ok = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
        if (!NATIVEPORRESET_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stretch_load = 1'b0;
        count_clr    = 1'b0;
        unique case (state_q)
            ST_RST: begin
                if (rst_ok) begin
                    state_d      = ST_STRETCH;
                    stretch_load = 1'b1;
                    count_clr    = 1'b1;
                end
            end
            ST_STRETCH: begin
                if (stretch_cnt == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (SWRESET_REQ) begin
                    state_d      = ST_SWRST;
                    stretch_load = 1'b1;
                    count_clr    = 1'b1;
                end
            end
            ST_SWRST: begin
                if (stretch_cnt == '0) begin
                    state_d = ST_ACKW;
                end
            end
            ST_ACKW: begin
                if (!SWRESET_REQ) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    assign run_q = (state_q == ST_RUN) || (state_q == ST_ACKW);
    assign run_d = (state_d == ST_RUN) || (state_d == ST_ACKW);

    always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
        if (!NATIVEPORRESET_n) begin
            stretch_cnt <= '0;
        end else if (stretch_load) begin
            stretch_cnt <= STRETCH_LOAD;
        end else if (((state_q == ST_STRETCH) || (state_q == ST_SWRST)) && (stretch_cnt != '0)) begin
            stretch_cnt <= stretch_cnt - 16'd1;
        end
    end

    // Divider only runs while staying in run states, so every run entry starts at phase 0.
    always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
        if (!NATIVEPORRESET_n) begin
            div_cnt <= '0;
        end else if (!(run_q && run_d)) begin
            div_cnt <= '0;
        end else if (!HALT) begin
            if (div_cnt == '0) begin
                div_cnt <= DIV_RATIO;
            end else begin
                div_cnt <= div_cnt - DIV_ONE;
            end
        end
    end

    always_comb begin
        CLKEN = 1'b1;
        if (run_q) begin
            CLKEN = ~HALT & (div_cnt == '0);
        end
    end

    always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
        if (!NATIVEPORRESET_n) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (run_q && CLKEN) begin
            count_q <= count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
        if (!NATIVEPORRESET_n) begin
            core_rst_n_q <= 1'b0;
        end else begin
            core_rst_n_q <= run_d;
        end
    end

    assign CORE_RESET_n = core_rst_n_q;
    assign RUN          = run_q;
    assign SWRESET_ACK  = (state_q == ST_ACKW);
    assign CLKEN_COUNT  = count_q;

endmodule

// File: tb/tb_v200_clkrst_seq.sv
// Directed bench for v200_clkrst_seq: POR release timing, divider, HALT,
// software reset handshake, mid-operation POR and CLKEN_COUNT wrap.
module tb_v200_clkrst_seq;

    logic        CLK2X = 1'b0;
    logic        NATIVEPORRESET_n;
    logic        SWRESET_REQ;
    logic        SWRESET_ACK;
    logic [3:0]  DIV_RATIO;
    logic        HALT;
    logic        CLKEN;
    logic        CORE_RESET_n;
    logic        RUN;
    logic [31:0] CLKEN_COUNT;

    int checks   = 0;
    int failures = 0;

    v200_clkrst_seq #(
        .STRETCH_CYCLES(16),
        .SYNC_STAGES   (2),
        .DIV_W         (4)
    ) dut (
        .CLK2X           (CLK2X),
        .NATIVEPORRESET_n(NATIVEPORRESET_n),
        .SWRESET_REQ     (SWRESET_REQ),
        .SWRESET_ACK     (SWRESET_ACK),
        .DIV_RATIO       (DIV_RATIO),
        .HALT            (HALT),
        .CLKEN           (CLKEN),
        .CORE_RESET_n    (CORE_RESET_n),
        .RUN             (RUN),
        .CLKEN_COUNT     (CLKEN_COUNT)
    );

    always #5 CLK2X = ~CLK2X;

    task automatic tick();
        @(posedge CLK2X);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks CLKEN against a bit pattern (LSB = current cycle), one cycle per bit.
    task automatic clken_pattern(input string tag, input int n, input logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), {31'd0, CLKEN}, {31'd0, pat[i]});
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad;
        logic ack_seen;

        NATIVEPORRESET_n = 1'b0;
        SWRESET_REQ      = 1'b0;
        DIV_RATIO        = 4'd3;
        HALT             = 1'b0;

        // Reset values
        #1;
        check("rst_core_reset_n", {31'd0, CORE_RESET_n}, 32'd0);
        check("rst_clken",        {31'd0, CLKEN},        32'd1);
        check("rst_run",          {31'd0, RUN},          32'd0);
        check("rst_ack",          {31'd0, SWRESET_ACK},  32'd0);
        check("rst_count",        CLKEN_COUNT,           32'd0);
        repeat (5) tick();

        // Power-on release: CORE_RESET_n rises 19 edges later, CLKEN high throughout
        NATIVEPORRESET_n = 1'b1;
        n   = 0;
        bad = 0;
        while (!CORE_RESET_n && n < 40) begin
            if (CLKEN !== 1'b1) bad++;
            tick();
            n++;
        end
        check("por_release_edges", n,            19);
        check("por_clken_high",    bad,          0);
        check("por_count_at_rise", CLKEN_COUNT,  32'd0);
        check("por_run",           {31'd0, RUN}, 32'd1);

        // Divider, ratio 3: pulse every 4th cycle starting at the first run cycle
        for (int i = 0; i < 40; i++) begin
            check($sformatf("div3[%0d]", i), {31'd0, CLKEN}, {31'd0, (i % 4) == 0});
            tick();
        end
        check("div3_count", CLKEN_COUNT, 32'd10);
        check("div3_c40",   {31'd0, CLKEN}, 32'd1);
        tick();
        // Mid-period ratio change: old period finishes, then every 2 cycles
        DIV_RATIO = 4'd1;
        #1;
        clken_pattern("div_change", 9, 32'h0A8);
        check("div_change_count", CLKEN_COUNT, 32'd14);

        // HALT freezes phase and count
        DIV_RATIO = 4'd2;
        tick();
        check("halt_pre_count", CLKEN_COUNT, 32'd15);
        HALT = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("halt_clken[%0d]", i), {31'd0, CLKEN}, 32'd0);
            check($sformatf("halt_count[%0d]", i), CLKEN_COUNT, 32'd15);
            tick();
        end
        HALT = 1'b0;
        #1;
        clken_pattern("halt_resume", 6, 32'h24);
        check("halt_resume_count", CLKEN_COUNT, 32'd17);

        // Software reset handshake
        SWRESET_REQ = 1'b1;
        tick();
        check("sw_core_reset_low", {31'd0, CORE_RESET_n}, 32'd0);
        check("sw_run_low",        {31'd0, RUN},          32'd0);
        check("sw_clken_high",     {31'd0, CLKEN},        32'd1);
        check("sw_ack_low",        {31'd0, SWRESET_ACK},  32'd0);
        check("sw_count_clr",      CLKEN_COUNT,           32'd0);
        n = 0;
        while (!CORE_RESET_n && n < 40) begin
            tick();
            n++;
        end
        check("sw_stretch_len", n, 16);
        check("sw_ack_high",    {31'd0, SWRESET_ACK}, 32'd1);
        check("sw_run_high",    {31'd0, RUN},         32'd1);
        check("sw_clken_first", {31'd0, CLKEN},       32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("sw_hold_ack[%0d]", i),  {31'd0, SWRESET_ACK},  32'd1);
            check($sformatf("sw_hold_core[%0d]", i), {31'd0, CORE_RESET_n}, 32'd1);
        end
        check("sw_hold_count", CLKEN_COUNT, 32'd4);
        SWRESET_REQ = 1'b0;
        #1;
        check("sw_ack_same_cycle", {31'd0, SWRESET_ACK}, 32'd1);
        tick();
        check("sw_ack_drop",  {31'd0, SWRESET_ACK},  32'd0);
        check("sw_back_run",  {31'd0, RUN},          32'd1);
        check("sw_back_core", {31'd0, CORE_RESET_n}, 32'd1);

        // POR in the middle of a software reset stretch
        SWRESET_REQ = 1'b1;
        tick();
        repeat (7) tick();
        check("mid_stretch_cnt", {16'd0, dut.stretch_cnt}, 32'd8);
        NATIVEPORRESET_n = 1'b0;
        SWRESET_REQ      = 1'b0;
        #1;
        check("mid_por_core",  {31'd0, CORE_RESET_n}, 32'd0);
        check("mid_por_ack",   {31'd0, SWRESET_ACK},  32'd0);
        check("mid_por_run",   {31'd0, RUN},          32'd0);
        check("mid_por_clken", {31'd0, CLKEN},        32'd1);
        check("mid_por_count", CLKEN_COUNT,           32'd0);
        repeat (3) tick();
        NATIVEPORRESET_n = 1'b1;
        n        = 0;
        ack_seen = 1'b0;
        while (!CORE_RESET_n && n < 40) begin
            ack_seen |= SWRESET_ACK;
            tick();
            n++;
        end
        ack_seen |= SWRESET_ACK;
        check("mid_por_release_edges", n, 19);
        check("mid_por_ack_seen",      {31'd0, ack_seen}, 32'd0);

        // CLKEN_COUNT wrap with CLKEN every cycle
        DIV_RATIO = 4'd0;
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        tick();
        check("wrap_ffffffff", CLKEN_COUNT, 32'hFFFF_FFFF);
        tick();
        check("wrap_zero",     CLKEN_COUNT, 32'h0000_0000);
        tick();
        check("wrap_one",      CLKEN_COUNT, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
